gstage_ptw_sv39x4: RTL and testbench

//  G-stage (Sv39x4) page-table walker: the producer of the gtlb update port. On a G-TLB miss it walks
//  the hgatp-rooted table through a single-outstanding memory read port, validates each PTE, and either

---
 rtl/gstage_ptw_sv39x4.sv | 222 ++++++++++++++++++++++
 tb/tb_gstage_ptw_sv39x4.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gstage_ptw_sv39x4.sv
// G-stage (Sv39x4) page-table walker producing G-TLB fills or guest-page faults.
// Optional `GPTW_PERF_CNT_EN adds saturating walk_cnt_o / fault_cnt_o counters.
module gstage_ptw_sv39x4 #(
    parameter int unsigned VMID_WIDTH = 1,
    parameter int unsigned GPLEN      = 41,
    parameter int unsigned PLEN       = 56
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  flush_i,
    input  logic                  walk_req_i,
    input  logic [GPLEN-1:0]      walk_gpaddr_i,
    input  logic [VMID_WIDTH-1:0] walk_vmid_i,
    input  logic [43:0]           hgatp_ppn_i,
    output logic                  walk_ready_o,
    output logic                  mem_req_o,
    output logic [PLEN-1:0]       mem_addr_o,
    input  logic                  mem_gnt_i,
    input  logic                  mem_rvalid_i,
    input  logic [63:0]           mem_rdata_i,
    output logic                  update_valid_o,
    output logic [VMID_WIDTH-1:0] update_vmid_o,
    output logic [GPLEN-13:0]     update_gppn_o,
    output logic                  update_is_2M_o,
    output logic                  update_is_1G_o,
    output logic [63:0]           update_content_o,
    output logic                  fault_o,
    output logic [GPLEN-1:0]      fault_gpaddr_o
`ifdef GPTW_PERF_CNT_EN
    ,
    output logic [31:0]           walk_cnt_o,
    output logic [31:0]           fault_cnt_o
`endif
);

    localparam int unsigned PPN_W = 44;
    localparam int unsigned IDX_W = 11;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ   = 3'd1,
        WAIT  = 3'd2,
        FILL  = 3'd3,
        FAULT = 3'd4,
        DRAIN = 3'd5
    } state_e;

    state_e                  state_q;
    logic [GPLEN-1:0]        gpaddr_q;
    logic [VMID_WIDTH-1:0]   vmid_q;
    logic [1:0]              level_q;
    logic [PPN_W-1:0]        base_q;
    logic [63:0]             pte_q;
    logic                    is_2m_q;
    logic                    is_1g_q;
    logic                    mem_req_q;
    logic                    walk_ready_q;
    logic                    upd_q;
    logic                    fault_q;

    logic [IDX_W-1:0]        idx;
    logic [PLEN-1:0]         pte_addr;
    logic                    accept;
    logic                    pte_leaf;
    logic                    pte_fault;
    logic                    fill_strobe;
    logic                    fault_strobe;

    assign accept = (state_q == IDLE) & walk_req_i & ~flush_i;

    // Table index for the current level; level 2 uses the widened x4 root index.
    always_comb begin
        idx = '0;
        case (level_q)
            2'd2:    idx = gpaddr_q[40:30];
            2'd1:    idx = {2'b00, gpaddr_q[29:21]};
            default: idx = {2'b00, gpaddr_q[20:12]};
        endcase
    end

    assign pte_addr = PLEN'({base_q, 12'h000}) + PLEN'({idx, 3'b000});

    // PTE validation in priority order: V, reserved R/W combo, leaf rules, pointer rules.
    always_comb begin
        pte_leaf  = mem_rdata_i[1] | mem_rdata_i[3];
        pte_fault = 1'b0;
        if (!mem_rdata_i[0] || (!mem_rdata_i[1] && mem_rdata_i[2])) begin
            pte_fault = 1'b1;
        end else if (pte_leaf) begin
            if (!mem_rdata_i[4]) begin
                pte_fault = 1'b1;
            end else if ((level_q == 2'd2) && (mem_rdata_i[27:10] != 18'd0)) begin
                pte_fault = 1'b1;
            end else if ((level_q == 2'd1) && (mem_rdata_i[18:10] != 9'd0)) begin
                pte_fault = 1'b1;
            end
        end else if ((level_q == 2'd0) || mem_rdata_i[6] || mem_rdata_i[7] || mem_rdata_i[4]) begin
            pte_fault = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            gpaddr_q     <= '0;
            vmid_q       <= '0;
            level_q      <= 2'd0;
            base_q       <= '0;
            pte_q        <= '0;
            is_2m_q      <= 1'b0;
            is_1g_q      <= 1'b0;
            mem_req_q    <= 1'b0;
            walk_ready_q <= 1'b1;
            upd_q        <= 1'b0;
            fault_q      <= 1'b0;
        end else begin
            upd_q   <= 1'b0;
            fault_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        state_q      <= REQ;
                        gpaddr_q     <= walk_gpaddr_i;
                        vmid_q       <= walk_vmid_i;
                        level_q      <= 2'd2;
                        base_q       <= hgatp_ppn_i;
                        mem_req_q    <= 1'b1;
                        walk_ready_q <= 1'b0;
                    end
                end
                REQ: begin
                    if (flush_i) begin
                        // A grant in the flush cycle leaves a response in flight.
                        state_q      <= mem_gnt_i ? DRAIN : IDLE;
                        mem_req_q    <= 1'b0;
                        walk_ready_q <= ~mem_gnt_i;
                    end else if (mem_gnt_i) begin
                        state_q   <= WAIT;
                        mem_req_q <= 1'b0;
                    end
                end
                WAIT: begin
                    if (flush_i) begin
                        state_q      <= mem_rvalid_i ? IDLE : DRAIN;
                        walk_ready_q <= mem_rvalid_i;
                    end else if (mem_rvalid_i) begin
                        if (pte_fault) begin
                            state_q <= FAULT;
                            fault_q <= 1'b1;
                        end else if (pte_leaf) begin
                            state_q <= FILL;
                            upd_q   <= 1'b1;
                            pte_q   <= mem_rdata_i;
                            is_1g_q <= (level_q == 2'd2);
                            is_2m_q <= (level_q == 2'd1);
                        end else begin
                            state_q   <= REQ;
                            level_q   <= 2'(level_q - 2'd1);
                            base_q    <= mem_rdata_i[53:10];
                            mem_req_q <= 1'b1;
                        end
                    end
                end
                FILL, FAULT: begin
                    state_q      <= IDLE;
                    walk_ready_q <= 1'b1;
                end
                DRAIN: begin
                    if (mem_rvalid_i) begin
                        state_q      <= IDLE;
                        walk_ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q      <= IDLE;
                    mem_req_q    <= 1'b0;
                    walk_ready_q <= 1'b1;
                end
            endcase
        end
    end

    // A flush in the strobe cycle still cancels the fill/fault toward the G-TLB.
    assign fill_strobe  = upd_q & ~flush_i;
    assign fault_strobe = fault_q & ~flush_i;

    assign walk_ready_o     = walk_ready_q;
    assign mem_req_o        = mem_req_q;
    assign mem_addr_o       = mem_req_q ? pte_addr : '0;
    assign update_valid_o   = fill_strobe;
    assign update_vmid_o    = fill_strobe ? vmid_q : '0;
    assign update_gppn_o    = fill_strobe ? gpaddr_q[GPLEN-1:12] : '0;
    assign update_is_2M_o   = fill_strobe & is_2m_q;
    assign update_is_1G_o   = fill_strobe & is_1g_q;
    assign update_content_o = fill_strobe ? pte_q : '0;
    assign fault_o          = fault_strobe;
    assign fault_gpaddr_o   = fault_strobe ? gpaddr_q : '0;

`ifdef GPTW_PERF_CNT_EN
    logic [31:0] walk_cnt_q;
    logic [31:0] fault_cnt_q;

    // Saturating event counters; only reset clears them.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            walk_cnt_q  <= '0;
            fault_cnt_q <= '0;
        end else begin
            if (accept && (walk_cnt_q != 32'hFFFF_FFFF)) begin
                walk_cnt_q <= walk_cnt_q + 32'd1;
            end
            if (fault_strobe && (fault_cnt_q != 32'hFFFF_FFFF)) begin
                fault_cnt_q <= fault_cnt_q + 32'd1;
            end
        end
    end

    assign walk_cnt_o  = walk_cnt_q;
    assign fault_cnt_o = fault_cnt_q;
`endif

endmodule

// File: tb/tb_gstage_ptw_sv39x4.sv
// Randomized bench for gstage_ptw_sv39x4 against a table-walking reference model.
module tb_gstage_ptw_sv39x4;

    localparam int unsigned VMID_WIDTH = 1;
    localparam int unsigned GPLEN      = 41;
    localparam int unsigned PLEN       = 56;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic                  flush;
    logic                  walk_req;
    logic [GPLEN-1:0]      walk_gpaddr;
    logic [VMID_WIDTH-1:0] walk_vmid;
    logic [43:0]           hgatp_ppn;
    logic                  walk_ready_o;
    logic                  mem_req_o;
    logic [PLEN-1:0]       mem_addr_o;
    logic                  mem_gnt;
    logic                  mem_rvalid;
    logic [63:0]           mem_rdata;
    logic                  update_valid_o;
    logic [VMID_WIDTH-1:0] update_vmid_o;
    logic [GPLEN-13:0]     update_gppn_o;
    logic                  update_is_2M_o;
    logic                  update_is_1G_o;
    logic [63:0]           update_content_o;
    logic                  fault_o;
    logic [GPLEN-1:0]      fault_gpaddr_o;
`ifdef GPTW_PERF_CNT_EN
    logic [31:0]           walk_cnt_o;
    logic [31:0]           fault_cnt_o;
`endif

    always #5 clk = ~clk;

    gstage_ptw_sv39x4 #(.VMID_WIDTH(VMID_WIDTH), .GPLEN(GPLEN), .PLEN(PLEN)) dut (
        .clk_i            (clk),
        .rst_ni           (rst_n),
        .flush_i          (flush),
        .walk_req_i       (walk_req),
        .walk_gpaddr_i    (walk_gpaddr),
        .walk_vmid_i      (walk_vmid),
        .hgatp_ppn_i      (hgatp_ppn),
        .walk_ready_o     (walk_ready_o),
        .mem_req_o        (mem_req_o),
        .mem_addr_o       (mem_addr_o),
        .mem_gnt_i        (mem_gnt),
        .mem_rvalid_i     (mem_rvalid),
        .mem_rdata_i      (mem_rdata),
        .update_valid_o   (update_valid_o),
        .update_vmid_o    (update_vmid_o),
        .update_gppn_o    (update_gppn_o),
        .update_is_2M_o   (update_is_2M_o),
        .update_is_1G_o   (update_is_1G_o),
        .update_content_o (update_content_o),
        .fault_o          (fault_o),
        .fault_gpaddr_o   (fault_gpaddr_o)
`ifdef GPTW_PERF_CNT_EN
        ,
        .walk_cnt_o       (walk_cnt_o),
        .fault_cnt_o      (fault_cnt_o)
`endif
    );

    int n_tests = 0;
    int n_fail  = 0;
    int n_accept = 0;
    int n_exp_fault = 0;

    logic [63:0] mem [logic [55:0]];
    logic [55:0] exp_addrs [$];
    logic [55:0] obs_addrs [$];
    logic        exp_fault;
    logic        exp_2m;
    logic        exp_1g;
    logic [63:0] exp_content;
    logic        obs_fill;
    logic        obs_fault;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] rd(input logic [55:0] a);
        return mem.exists(a) ? mem[a] : 64'h0;
    endfunction

    function automatic int level_idx(input logic [40:0] ga, input int lvl);
        if (lvl == 2) return int'(ga[40:30]);
        if (lvl == 1) return int'(ga[29:21]);
        return int'(ga[20:12]);
    endfunction

    // Lay out a table: pointers down to leaf_lvl (-1 = no leaf), one entry optionally corrupted.
    task automatic build(input logic [40:0] ga, input logic [43:0] root, input int leaf_lvl,
                         input int bad, input int bad_lvl);
        logic [43:0] base;
        logic [43:0] nppn;
        logic [63:0] pte;
        logic [55:0] a;
        mem.delete();
        base = root;
        for (int lvl = 2; lvl >= 0; lvl--) begin
            a    = 56'({base, 12'h000}) + 56'(level_idx(ga, lvl) * 8);
            nppn = {12'($urandom), 32'($urandom)};
            if (lvl == leaf_lvl) begin
                if (lvl == 2) nppn[17:0] = '0;
                if (lvl == 1) nppn[8:0] = '0;
                pte = {10'h0, nppn, 10'h0DF};
            end else begin
                pte = {10'h0, nppn, 10'h001};
            end
            if (lvl == bad_lvl) begin
                case (bad)
                    1: pte[0] = 1'b0;
                    2: begin pte[1] = 1'b0; pte[2] = 1'b1; end
                    3: pte[4] = 1'b0;
                    4: pte[10] = 1'b1;
                    5: pte[6] = 1'b1;
                    default: ;
                endcase
            end
            mem[a] = pte;
            if (lvl == leaf_lvl) break;
            base = nppn;
        end
    endtask

    // Reference walk straight from the translation rules.
    task automatic model_walk(input logic [40:0] ga, input logic [43:0] root);
        logic [43:0] base;
        logic [63:0] pte;
        logic [55:0] a;
        exp_addrs.delete();
        exp_fault = 1'b1; exp_2m = 1'b0; exp_1g = 1'b0; exp_content = '0;
        base = root;
        for (int lvl = 2; lvl >= 0; lvl--) begin
            a = 56'({base, 12'h000}) + 56'(level_idx(ga, lvl) * 8);
            exp_addrs.push_back(a);
            pte = rd(a);
            if (!pte[0] || (!pte[1] && pte[2])) return;
            if (pte[1] || pte[3]) begin
                if (!pte[4]) return;
                if (lvl == 2 && pte[27:10] != 18'd0) return;
                if (lvl == 1 && pte[18:10] != 9'd0) return;
                exp_fault = 1'b0; exp_1g = (lvl == 2); exp_2m = (lvl == 1); exp_content = pte;
                return;
            end
            if (lvl == 0 || pte[4] || pte[6] || pte[7]) return;
            base = pte[53:10];
        end
    endtask

    task automatic apply_reset();
        rst_n = 1'b0; flush = 0; walk_req = 0; walk_gpaddr = '0; walk_vmid = '0;
        hgatp_ppn = '0; mem_gnt = 0; mem_rvalid = 0; mem_rdata = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        n_accept = 0; n_exp_fault = 0;
    endtask

    // Drive one walk and act as memory; first_hold > 0 stalls the first grant that long.
    task automatic run_walk(input logic [40:0] ga, input logic vmid, input logic [43:0] root,
                            input int gmax, input int rmax, input bit chk_lat, input int first_hold);
        int gwait, rv_cnt, nreq, lat, stall;
        bit pend, done;
        logic [55:0] paddr;
        model_walk(ga, root);
        obs_addrs.delete();
        obs_fill = 0; obs_fault = 0;
        @(negedge clk);
        check("ready_before_walk", 64'(walk_ready_o), 64'd1);
        walk_req = 1; walk_gpaddr = ga; walk_vmid = vmid; hgatp_ppn = root;
        n_accept++;
        if (exp_fault) n_exp_fault++;
        pend = 0; done = 0; nreq = 0; lat = 0; stall = 0; rv_cnt = 0; paddr = '0;
        gwait = (first_hold > 0) ? first_hold : $urandom_range(0, gmax);
        while (!done && lat < 400) begin
            @(negedge clk);
            lat++;
            walk_req = 0; mem_gnt = 0; mem_rvalid = 0; mem_rdata = '0;
            if (update_valid_o || fault_o) begin
                done = 1;
                obs_fill = update_valid_o; obs_fault = fault_o;
                check("fault_strobe", 64'(fault_o), 64'(exp_fault));
                check("fill_strobe", 64'(update_valid_o), 64'(!exp_fault));
                check("req_count", 64'(nreq), 64'(exp_addrs.size()));
                if (exp_fault) begin
                    check("fault_gpaddr", 64'(fault_gpaddr_o), 64'(ga));
                    check("content_idle", update_content_o, 64'd0);
                end else begin
                    check("fill_gppn", 64'(update_gppn_o), 64'(ga[40:12]));
                    check("fill_vmid", 64'(update_vmid_o), 64'(vmid));
                    check("fill_2m", 64'(update_is_2M_o), 64'(exp_2m));
                    check("fill_1g", 64'(update_is_1G_o), 64'(exp_1g));
                    check("fill_content", update_content_o, exp_content);
                    check("gpaddr_idle", 64'(fault_gpaddr_o), 64'd0);
                end
                if (chk_lat) check("latency", 64'(lat), 64'(2 * exp_addrs.size() + 1));
            end else if (mem_req_o) begin
                if (nreq < exp_addrs.size()) check("mem_addr", 64'(mem_addr_o), 64'(exp_addrs[nreq]));
                else check("req_count", 64'(nreq + 1), 64'(exp_addrs.size()));
                if (gwait == 0) begin
                    if (nreq == 0 && first_hold > 0) check("bp_stall_cycles", 64'(stall), 64'(first_hold));
                    mem_gnt = 1; paddr = mem_addr_o; pend = 1;
                    obs_addrs.push_back(mem_addr_o);
                    rv_cnt = $urandom_range(1, rmax); nreq++;
                    gwait = $urandom_range(0, gmax);
                end else begin
                    gwait--;
                    if (nreq == 0) stall++;
                end
            end else if (pend) begin
                rv_cnt--;
                if (rv_cnt == 0) begin
                    mem_rvalid = 1; mem_rdata = rd(paddr); pend = 0;
                end
            end
        end
        check("walk_done", 64'(done), 64'd1);
        @(negedge clk);
        check("strobe_one_cycle", 64'({update_valid_o, fault_o}), 64'd0);
        check("ready_after_walk", 64'(walk_ready_o), 64'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [40:0] ga;
        logic [43:0] root;
        apply_reset();
        @(negedge clk);
        check("rst_ready", 64'(walk_ready_o), 64'd1);
        check("rst_mem_req", 64'(mem_req_o), 64'd0);
        check("rst_mem_addr", 64'(mem_addr_o), 64'd0);
        check("rst_update", 64'({update_valid_o, update_is_2M_o, update_is_1G_o}), 64'd0);
        check("rst_fault", 64'(fault_o), 64'd0);
        check("rst_gpaddr", 64'(fault_gpaddr_o), 64'd0);

        // Reference 4K walk with a fixed leaf PTE.
        ga = 41'h1_2345_6000; root = 44'h80000;
        build(ga, root, 0, 0, -1);
        model_walk(ga, root);
        mem[exp_addrs[2]] = 64'h2000_00DF;
        run_walk(ga, 1'b1, root, 0, 1, 1, 0);
        check("ex_fill", 64'(obs_fill), 64'd1);
        check("ex_l2_addr", 64'(obs_addrs.size() > 0 ? obs_addrs[0] : 56'd0), 64'h8000_0020);
        check("ex_l1_off", 64'(obs_addrs.size() > 1 ? obs_addrs[1][11:0] : 12'd0), 64'h8D0);
        check("ex_l0_off", 64'(obs_addrs.size() > 2 ? obs_addrs[2][11:0] : 12'd0), 64'h2B0);

        // Superpage boundaries and individual fault rules.
        ga = {9'($urandom), 32'($urandom)}; root = {12'($urandom), 32'($urandom)};
        build(ga, root, 1, 0, -1);  run_walk(ga, 1'b0, root, 0, 1, 1, 0);
        check("2m_aligned_fill", 64'(obs_fill), 64'd1);
        build(ga, root, 1, 4, 1);   run_walk(ga, 1'b0, root, 0, 1, 1, 0);
        check("2m_misaligned_fault", 64'(obs_fault), 64'd1);
        build(ga, root, 2, 0, -1);  run_walk(ga, 1'b1, root, 0, 1, 1, 0);
        check("1g_fill", 64'(obs_fill), 64'd1);
        build(ga, root, 0, 1, 2);   run_walk(ga, 1'b0, root, 0, 1, 1, 0);
        check("v0_l2_fault", 64'(obs_fault), 64'd1);
        build(ga, root, 0, 2, 1);   run_walk(ga, 1'b0, root, 0, 1, 1, 0);
        check("r0w1_fault", 64'(obs_fault), 64'd1);
        build(ga, root, 0, 3, 0);   run_walk(ga, 1'b0, root, 0, 1, 1, 0);
        check("leaf_u0_fault", 64'(obs_fault), 64'd1);
        build(ga, root, -1, 0, -1); run_walk(ga, 1'b0, root, 0, 1, 1, 0);
        check("nonleaf_l0_fault", 64'(obs_fault), 64'd1);

        // Grant withheld for 5 cycles on the first request.
        build(ga, root, 0, 0, -1);  run_walk(ga, 1'b1, root, 0, 2, 0, 5);

        // Flush while waiting for data; response arrives 3 cycles later.
        build(ga, root, 0, 0, -1);
        @(negedge clk);
        walk_req = 1; walk_gpaddr = ga; hgatp_ppn = root; n_accept++;
        @(negedge clk);
        walk_req = 0;
        check("flush_req_seen", 64'(mem_req_o), 64'd1);
        mem_gnt = 1;
        @(negedge clk);
        mem_gnt = 0; flush = 1;
        @(negedge clk);
        flush = 0;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) @(negedge clk);
            check("drain_not_ready", 64'(walk_ready_o), 64'd0);
            check("drain_no_strobe", 64'({update_valid_o, fault_o, mem_req_o}), 64'd0);
            if (i == 2) begin mem_rvalid = 1; mem_rdata = 64'h2000_00DF; end
        end
        @(negedge clk);
        mem_rvalid = 0; mem_rdata = '0;
        check("drain_ready", 64'(walk_ready_o), 64'd1);
        check("drain_no_strobe_end", 64'({update_valid_o, fault_o}), 64'd0);

        // Flush beats a simultaneous request in IDLE.
        @(negedge clk);
        walk_req = 1; flush = 1;
        @(negedge clk);
        walk_req = 0; flush = 0;
        check("flush_wins_ready", 64'(walk_ready_o), 64'd1);
        check("flush_wins_no_req", 64'(mem_req_o), 64'd0);

        // Randomized walks with random grant/response delays.
        for (int n = 0; n < 40; n++) begin
            ga = {9'($urandom), 32'($urandom)}; root = {12'($urandom), 32'($urandom)};
            build(ga, root, int'($urandom_range(0, 3)) - 1, int'($urandom_range(0, 5)),
                  int'($urandom_range(0, 2)));
            run_walk(ga, 1'($urandom), root, 3, 4, 0, 0);
        end

`ifdef GPTW_PERF_CNT_EN
        @(negedge clk);
        check("walk_cnt", 64'(walk_cnt_o), 64'(n_accept));
        check("fault_cnt", 64'(fault_cnt_o), 64'(n_exp_fault));
`endif

        // Reset in the middle of a walk; a late response is ignored.
        build(ga, root, 0, 0, -1);
        @(negedge clk);
        walk_req = 1; walk_gpaddr = ga; hgatp_ppn = root;
        @(negedge clk);
        walk_req = 0; mem_gnt = 1;
        @(negedge clk);
        mem_gnt = 0; rst_n = 0;
        #1;
        check("midreset_ready", 64'(walk_ready_o), 64'd1);
        check("midreset_no_req", 64'(mem_req_o), 64'd0);
        @(negedge clk);
        rst_n = 1; n_accept = 0; n_exp_fault = 0;
        mem_rvalid = 1; mem_rdata = 64'h2000_00DF;
        @(negedge clk);
        mem_rvalid = 0; mem_rdata = '0;
        @(negedge clk);
        check("late_rvalid_ready", 64'(walk_ready_o), 64'd1);
        check("late_rvalid_quiet", 64'({update_valid_o, fault_o, mem_req_o}), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
